// File: rtl/rf_wb_arb_pkg.sv
// ============================================================================
// Module      : rf_wb_arb_pkg
// Description : Shared widths, x0 address and arbiter state encodings
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_wb_arb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE1 = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arb.sv
// ============================================================================
// Module      : rf_wb_arb
// Description : Two-port register-file writeback arbiter with starvation guard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_AW-1:0] req0_wR,
    input  logic [DATA_W-1:0] req0_wD,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_AW-1:0] req1_wR,
    input  logic [DATA_W-1:0] req1_wD,

    output logic              rf_we,
    output logic [REG_AW-1:0] wR,
    output logic [DATA_W-1:0] wD
);

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rf_we_q;
    logic [REG_AW-1:0] wR_q;
    logic [DATA_W-1:0] wD_q;

    logic              w_gnt0, w_gnt1, w_xfer;
    logic [REG_AW-1:0] w_sel_wr;
    logic [DATA_W-1:0] w_sel_wd;

    // Grant is purely combinational so a transfer can happen every cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (state_q == ST_FORCE1) begin
                w_gnt1 = req1_valid;
                w_gnt0 = req0_valid && !req1_valid;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid && !req0_valid;
            end
        end
    end

    assign w_xfer   = w_gnt0 || w_gnt1;
    assign w_sel_wr = w_gnt1 ? req1_wR : req0_wR;
    assign w_sel_wd = w_gnt1 ? req1_wD : req0_wD;

    // The switch to FORCE1 looks at the updated count so that req1 wins on the
    // cycle right after its STARVE_MAX-th consecutive loss.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        state_d      = ST_NORMAL;
        if (w_gnt1) begin
            starve_cnt_d = '0;
        end else if (req1_valid) begin
            if (starve_cnt_q < c_starve_max) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
            if (state_q == ST_NORMAL && starve_cnt_d == c_starve_max) begin
                state_d = ST_FORCE1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            wR_q         <= '0;
            wD_q         <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= w_xfer && (w_sel_wr != REG_X0);
            if (w_xfer) begin
                wR_q <= w_sel_wr;
                wD_q <= w_sel_wd;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rf_we      = rf_we_q;
    assign wR         = wR_q;
    assign wD         = wD_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arb.sv
// ============================================================================
// Module      : tb_rf_wb_arb
// Description : Self-checking bench for rf_wb_arb, directed plus random
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arb;

    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_wR, req1_wR, wR;
    logic [31:0] req0_wD, req1_wD, wD;
    logic        rf_we;

    int total = 0;
    int bad   = 0;

    rf_wb_arb #(.STARVE_MAX(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wR    (req0_wR),
        .req0_wD    (req0_wD),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wR    (req1_wR),
        .req1_wD    (req1_wD),
        .rf_we      (rf_we),
        .wR         (wR),
        .wD         (wD)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_wR = 5'd0; req0_wD = 32'd0;
        req1_wR = 5'd0; req1_wD = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        req0_valid = 1'b1; req0_wR = 5'd9;  req0_wD = 32'hDEAD;
        req1_valid = 1'b1; req1_wR = 5'd10; req1_wD = 32'hBEEF;
        #1;
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        tick(); tick();
        total++;
        if (rf_we !== 1'b0 || wR !== 5'd0 || wD !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b wR=%0d wD=%h want 0 0 0", rf_we, wR, wD);
        end
        // First grant must be possible in the very first cycle out of reset.
        rst = 1'b0;
        req1_valid = 1'b0;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: got r0=%b want 1", req0_ready);
        end
        tick();
        total++;
        if (rf_we !== 1'b1 || wR !== 5'd9 || wD !== 32'hDEAD) begin
            bad++;
            $display("FAIL first_write: got we=%b wR=%0d wD=%h want 1 9 dead", rf_we, wR, wD);
        end
        idle_inputs();
    endtask

    task automatic test_req0_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req0_wR = 5'(i + 1);
            req0_wD = 32'hA0 + 32'(i);
            #2;
            total++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL stream_ready[%0d]: got r0=%b r1=%b want 1 0", i, req0_ready, req1_ready);
            end
            tick();
            total++;
            if (rf_we !== 1'b1 || wR !== 5'(i + 1) || wD !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL stream_write[%0d]: got we=%b wR=%0d wD=%h want 1 %0d %h",
                         i, rf_we, wR, wD, i + 1, 32'hA0 + 32'(i));
            end
        end
        idle_inputs();
        tick();
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL stream_idle_we: got %b want 0", rf_we);
        end
    endtask

    task automatic test_fairness();
        logic g1;
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_wR = 5'd20; req1_wD = 32'h1111_0000;
        for (int c = 0; c < 12; c++) begin
            req0_wR = 5'(c + 1);
            req0_wD = 32'h5000 + 32'(c);
            g1 = (c % 4 == 3);
            #2;
            total++;
            if (req0_ready !== !g1 || req1_ready !== g1) begin
                bad++;
                $display("FAIL fair_grant[%0d]: got r0=%b r1=%b want %b %b",
                         c, req0_ready, req1_ready, !g1, g1);
            end
            tick();
            total++;
            if (rf_we !== 1'b1 || wR !== (g1 ? 5'd20 : 5'(c + 1))) begin
                bad++;
                $display("FAIL fair_write[%0d]: got we=%b wR=%0d want 1 %0d",
                         c, rf_we, wR, g1 ? 20 : c + 1);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        req0_valid = 1'b1; req0_wR = 5'd3; req0_wD = 32'h33;
        req1_valid = 1'b1; req1_wR = 5'd0; req1_wD = 32'h77;
        tick();
        req0_valid = 1'b0;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_ready: got r1=%b want 1", req1_ready);
        end
        tick();
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL x0_we: got %b want 0", rf_we);
        end
        // A cleared counter means req1 loses three times before it wins again.
        req0_valid = 1'b1; req1_wR = 5'd7;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (req1_ready !== (c == 3)) begin
                bad++;
                $display("FAIL x0_cnt_clear[%0d]: got r1=%b want %b", c, req1_ready, c == 3);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_wR = 5'd4; req0_wD = 32'h44;
        req1_valid = 1'b1; req1_wR = 5'd6; req1_wD = 32'h66;
        tick(); tick();
        rst = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready);
        end
        tick();
        rst = 1'b0;
        total++;
        if (rf_we !== 1'b0 || wR !== 5'd0 || wD !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_out: got we=%b wR=%0d wD=%h want 0 0 0", rf_we, wR, wD);
        end
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (req0_ready !== (c != 3) || req1_ready !== (c == 3)) begin
                bad++;
                $display("FAIL rstmid_cnt[%0d]: got r0=%b r1=%b want %b %b",
                         c, req0_ready, req1_ready, c != 3, c == 3);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_reg();
        logic [31:0] reg5;
        int          writes;
        reg5 = 32'd0;
        writes = 0;
        do_reset();
        req0_valid = 1'b1; req0_wR = 5'd5; req0_wD = 32'h11;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++;
            $display("FAIL same_r0_ready: got %b want 1", req0_ready);
        end
        tick();
        total++;
        if (rf_we !== 1'b1 || wR !== 5'd5 || wD !== 32'h11) begin
            bad++;
            $display("FAIL same_first: got we=%b wR=%0d wD=%h want 1 5 11", rf_we, wR, wD);
        end
        if (rf_we === 1'b1 && wR === 5'd5) begin reg5 = wD; writes++; end
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_wR = 5'd5; req1_wD = 32'h22;
        tick();
        total++;
        if (rf_we !== 1'b1 || wR !== 5'd5 || wD !== 32'h22) begin
            bad++;
            $display("FAIL same_second: got we=%b wR=%0d wD=%h want 1 5 22", rf_we, wR, wD);
        end
        if (rf_we === 1'b1 && wR === 5'd5) begin reg5 = wD; writes++; end
        idle_inputs();
        tick();
        total++;
        if (reg5 !== 32'h22 || writes != 2) begin
            bad++;
            $display("FAIL same_final: got reg5=%h writes=%0d want 22 2", reg5, writes);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req0_valid = 1'b1; req0_wR = 5'd8; req0_wD = 32'h88;
        req1_valid = 1'b1; req1_wR = 5'd9; req1_wD = 32'h99;
        tick(); tick();
        req1_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin
                bad++;
                $display("FAIL hold_idle[%0d]: got r0=%b r1=%b want 1 0", c, req0_ready, req1_ready);
            end
            tick();
        end
        req1_valid = 1'b1;
        #1;
        total++;
        if (req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_loss: got r1=%b want 0", req1_ready);
        end
        tick();
        total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_force: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    // Reference: req1 is forced after SM consecutive losses; otherwise req0 wins.
    task automatic test_random();
        int          losses;
        bit          forced;
        bit          p0, p1, e0, e1, exp_we;
        logic [4:0]  a0, a1, exp_wr;
        logic [31:0] d0, d1, exp_wd;
        losses = 0; forced = 1'b0; p0 = 1'b0; p1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1;
                a0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1'b1;
                a1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                d1 = $urandom;
            end
            req0_valid = p0; req0_wR = a0; req0_wD = d0;
            req1_valid = p1; req1_wR = a1; req1_wD = d1;
            e1 = p1 && (!p0 || forced);
            e0 = p0 && !e1;
            #2;
            total++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                bad++;
                $display("FAIL rand_grant[%0d]: got r0=%b r1=%b want %b %b",
                         c, req0_ready, req1_ready, e0, e1);
            end
            exp_we = (e0 || e1) && ((e1 ? a1 : a0) != 5'd0);
            exp_wr = e1 ? a1 : a0;
            exp_wd = e1 ? d1 : d0;
            tick();
            total++;
            if (rf_we !== exp_we || (exp_we && (wR !== exp_wr || wD !== exp_wd))) begin
                bad++;
                $display("FAIL rand_write[%0d]: got we=%b wR=%0d wD=%h want %b %0d %h",
                         c, rf_we, wR, wD, exp_we, exp_wr, exp_wd);
            end
            if (e1) begin
                losses = 0;
                forced = 1'b0;
            end else if (p1) begin
                if (losses < SM) losses++;
                forced = (losses == SM);
            end
            if (e0) p0 = 1'b0;
            if (e1) p1 = 1'b0;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_req0_stream();
        test_fairness();
        test_x0();
        test_reset_mid();
        test_same_reg();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
